wb_config_responder: RTL and testbench

- Wishbone classic slave that receives fabric configuration writes from the management SoC.
- Deserialises each written data byte into a per-column serial bitstream: one bit per cycle on col_bit, qualified by col_shift.
- Pulses col_set to latch a column's chain once its programmed bit count is exhausted.
- One instance per config region of NUM_COLS columns, sitting between the caravel Wishbone bus and the fabric column shift chains.

---
 rtl/config_wb_pkg.sv | 30 +++
 rtl/config_col_serializer.sv | 90 +++++++++
 rtl/wb_config_responder.sv | 156 +++++++++++++++
 tb/tb_wb_config_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_wb_pkg.sv
// Shared definitions for the Wishbone configuration responder: register
// offsets, the column count sentinel, the shift length and the FSM states.
package config_wb_pkg;

    // Byte offsets of the registers inside the region (0xC is reserved)
    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_COUNT  = 4'h4;
    localparam logic [3:0] REG_DATA   = 4'h8;

    // A column count of all ones means "shift forever, never latch"
    localparam logic [7:0] COUNT_INF = 8'hFF;

    // Every DATA write occupies exactly this many shift cycles
    localparam int SHIFT_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Number of bits a column emits from one written byte: min(count, 8)
    function automatic logic [3:0] shiftCount(input logic [7:0] count);
        if (count > 8'd8) begin
            return 4'd8;
        end
        return count[3:0];
    endfunction

endpackage

// File: rtl/config_col_serializer.sv
// One column's slice of the responder: holds the latched byte, the number of
// bits to emit for it, the remaining bit count, the done flag and the col_set
// pulse. The parent supplies the shared shift index and the commit strobe.
module config_col_serializer
    import config_wb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       countWr_i,
    input  logic [7:0] countData_i,
    input  logic       dataWr_i,
    input  logic [7:0] dataByte_i,
    input  logic       shiftEn_i,
    input  logic [2:0] shiftK_i,
    input  logic       commit_i,
    output logic       colShift_o,
    output logic       colBit_o,
    output logic       colSet_o,
    output logic [7:0] count_o,
    output logic       done_o
);

    logic [7:0] byte_q,   byte_d;
    logic [3:0] nBits_q,  nBits_d;
    logic [7:0] count_q,  count_d;
    logic       done_q,   done_d;
    logic       active_q, active_d;
    logic       set_q,    set_d;
    logic [7:0] remaining;

    assign remaining = count_q - {4'b0000, nBits_q};

    // Next-state: COUNT writes reload the counter, DATA writes latch the byte,
    // and the commit strobe (last shift cycle) retires the bits just emitted so
    // the new count and any col_set pulse coincide with the ack cycle.
    always_comb begin
        byte_d   = byte_q;
        nBits_d  = nBits_q;
        count_d  = count_q;
        done_d   = done_q;
        active_d = active_q;
        set_d    = 1'b0;
        if (countWr_i) begin
            count_d = countData_i;
            done_d  = 1'b0;
        end
        if (dataWr_i) begin
            byte_d   = dataByte_i;
            nBits_d  = shiftCount(count_q);
            active_d = 1'b1;
        end
        if (commit_i && active_q) begin
            active_d = 1'b0;
            if (count_q != COUNT_INF) begin
                count_d = remaining;
                if (remaining == 8'd0) begin
                    done_d = 1'b1;
                    set_d  = 1'b1;
                end
            end
        end
    end

    // Column state registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_q   <= 8'h00;
            nBits_q  <= 4'd0;
            count_q  <= COUNT_INF;
            done_q   <= 1'b0;
            active_q <= 1'b0;
            set_q    <= 1'b0;
        end else begin
            byte_q   <= byte_d;
            nBits_q  <= nBits_d;
            count_q  <= count_d;
            done_q   <= done_d;
            active_q <= active_d;
            set_q    <= set_d;
        end
    end

    // Bits go out LSB first; only the first nBits shift cycles are qualified
    assign colShift_o = active_q && shiftEn_i && ({1'b0, shiftK_i} < nBits_q);
    assign colBit_o   = colShift_o && byte_q[shiftK_i];
    assign colSet_o   = set_q;
    assign count_o    = count_q;
    assign done_o     = done_q;

endmodule

// File: rtl/wb_config_responder.sv
// Wishbone classic slave that turns configuration writes into per-column
// serial bitstreams. The FSM, address decode, shared shift index and bus
// response live here; per-column state lives in config_col_serializer.
module wb_config_responder
    import config_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_COLS  = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_data_i,
    input  logic [31:0]         wbs_addr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_data_o,
    output logic [NUM_COLS-1:0] col_shift,
    output logic [NUM_COLS-1:0] col_bit,
    output logic [NUM_COLS-1:0] col_set,
    output logic                busy
);

    state_e      state_q;
    logic [2:0]  kCnt_q;
    logic        ack_q;
    logic [31:0] rdata_q;

    logic [3:0]  regOffset;
    logic        addrHit;
    logic        request;
    logic        countWrite;
    logic        dataWrite;
    logic        shiftEn;
    logic        commit;
    logic [3:0]  laneActive;
    logic [31:0] readData;
    logic [1:0]  unusedAddrBits;

    logic [3:0]      shiftAll;
    logic [3:0]      bitAll;
    logic [3:0]      setAll;
    logic [3:0]      doneAll;
    logic [3:0][7:0] countAll;

    assign unusedAddrBits = wbs_addr_i[1:0];

    assign regOffset  = {wbs_addr_i[3:2], 2'b00};
    assign addrHit    = (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
    assign request    = wbs_stb_i && wbs_cyc_i && addrHit && (state_q == ST_IDLE);
    assign countWrite = request && wbs_we_i && (regOffset == REG_COUNT);
    assign dataWrite  = request && wbs_we_i && (regOffset == REG_DATA);
    assign shiftEn    = (state_q == ST_SHIFT);
    assign commit     = shiftEn && (kCnt_q == 3'(SHIFT_LEN - 1));

    // A lane takes part only if selected and backed by a real column
    always_comb begin
        laneActive = 4'b0000;
        for (int c = 0; c < NUM_COLS; c++) begin
            laneActive[c] = wbs_sel_i[c];
        end
    end

    // One serializer per populated column; missing lanes read back as zero
    for (genvar c = 0; c < 4; c++) begin : g_col
        if (c < NUM_COLS) begin : g_present
            config_col_serializer u_col (
                .clk_i       (wb_clk_i),
                .rst_ni      (wb_rst_i),
                .countWr_i   (countWrite && laneActive[c]),
                .countData_i (wbs_data_i[8*c +: 8]),
                .dataWr_i    (dataWrite && laneActive[c]),
                .dataByte_i  (wbs_data_i[8*c +: 8]),
                .shiftEn_i   (shiftEn),
                .shiftK_i    (kCnt_q),
                .commit_i    (commit),
                .colShift_o  (shiftAll[c]),
                .colBit_o    (bitAll[c]),
                .colSet_o    (setAll[c]),
                .count_o     (countAll[c]),
                .done_o      (doneAll[c])
            );
        end else begin : g_absent
            assign shiftAll[c] = 1'b0;
            assign bitAll[c]   = 1'b0;
            assign setAll[c]   = 1'b0;
            assign countAll[c] = 8'h00;
            assign doneAll[c]  = 1'b0;
        end
    end

    // Read mux; busy in STATUS is always 0 because reads are only taken in IDLE
    always_comb begin
        readData = 32'h0000_0000;
        case (regOffset)
            REG_STATUS: readData = {23'b0, 1'b0, 4'b0, doneAll};
            REG_COUNT:  readData = countAll;
            default:    readData = 32'h0000_0000;
        endcase
    end

    // Bus FSM: register accesses ack next cycle, DATA writes shift 8 cycles first
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            kCnt_q  <= 3'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q   <= 1'b0;
                    rdata_q <= 32'h0000_0000;
                    if (request) begin
                        if (dataWrite) begin
                            state_q <= ST_SHIFT;
                            kCnt_q  <= 3'd0;
                        end else begin
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                            rdata_q <= wbs_we_i ? 32'h0000_0000 : readData;
                        end
                    end
                end
                ST_SHIFT: begin
                    kCnt_q <= kCnt_q + 3'd1;
                    if (commit) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= 32'h0000_0000;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= 32'h0000_0000;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_data_o = rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign col_shift  = shiftAll[NUM_COLS-1:0];
    assign col_bit    = bitAll[NUM_COLS-1:0];
    assign col_set    = setAll[NUM_COLS-1:0];

endmodule

// File: tb/tb_wb_config_responder.sv
// Directed bench for wb_config_responder. A behavioural model predicts a
// per-cycle record (ack, read data, column outputs, busy) for every access;
// records are queued when the access is driven and compared as cycles elapse.
module tb_wb_config_responder;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_data_i = 32'h0;
    logic [31:0] wbs_addr_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_data_o;
    logic [3:0]  col_shift;
    logic [3:0]  col_bit;
    logic [3:0]  col_set;
    logic        busy;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic [3:0]  shift;
        logic [3:0]  bits;
        logic [3:0]  set;
        logic        busy;
    } exp_t;

    exp_t       expQ[$];
    int         assertCount = 0;
    int         failCount = 0;
    logic [7:0] modelCount[4];
    logic       modelDone[4];

    wb_config_responder #(
        .BASE_ADDR (32'h3000_0000),
        .NUM_COLS  (4)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_data_i (wbs_data_i),
        .wbs_addr_i (wbs_addr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_data_o (wbs_data_o),
        .col_shift  (col_shift),
        .col_bit    (col_bit),
        .col_set    (col_set),
        .busy       (busy)
    );

    // 100 MHz clock
    always #5 wb_clk_i = ~wb_clk_i;

    function automatic exp_t idleRec();
        exp_t e;
        e.ack   = 1'b0;
        e.rdata = 32'h0;
        e.shift = 4'h0;
        e.bits  = 4'h0;
        e.set   = 4'h0;
        e.busy  = 1'b0;
        return e;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 4; c++) begin
            modelCount[c] = 8'hFF;
            modelDone[c]  = 1'b0;
        end
    endtask

    task automatic pushIdle(input int n);
        repeat (n) expQ.push_back(idleRec());
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Compare the DUT outputs of the current cycle against the oldest record
    task automatic checkOne(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL %s: observed empty scoreboard expected a record", tag);
        end else begin
            e = expQ.pop_front();
            checkValue({tag, ".ack"},   32'(wbs_ack_o),  32'(e.ack));
            checkValue({tag, ".data"},  wbs_data_o,      e.rdata);
            checkValue({tag, ".shift"}, 32'(col_shift),  32'(e.shift));
            checkValue({tag, ".bit"},   32'(col_bit),    32'(e.bits));
            checkValue({tag, ".set"},   32'(col_set),    32'(e.set));
            checkValue({tag, ".busy"},  32'(busy),       32'(e.busy));
        end
    endtask

    task automatic checkCycles(input string tag, input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
            @(negedge wb_clk_i);
            checkOne(tag);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkCycles(tag, expQ.size());
    endtask

    // Drive one access and queue the cycle-by-cycle response the model predicts
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel);
        exp_t       e;
        logic       hit;
        logic [1:0] off;
        logic [3:0] nBits[4];
        logic [7:0] b[4];
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i  = 1'b1;
        wbs_cyc_i  = 1'b1;
        wbs_we_i   = we;
        wbs_addr_i = addr;
        wbs_data_i = data;
        wbs_sel_i  = sel;
        hit = (addr[31:4] == 28'h300_0000);
        off = addr[3:2];
        if (!hit) begin
            pushIdle(3);
        end else if (we && off == 2'd2) begin
            for (int c = 0; c < 4; c++) begin
                b[c] = data[8*c +: 8];
                if (!sel[c]) nBits[c] = 4'd0;
                else if (modelCount[c] > 8'd8) nBits[c] = 4'd8;
                else nBits[c] = modelCount[c][3:0];
            end
            for (int k = 0; k < 8; k++) begin
                e = idleRec();
                e.busy = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    e.shift[c] = (k < int'(nBits[c]));
                    e.bits[c]  = e.shift[c] & b[c][k];
                end
                expQ.push_back(e);
            end
            e = idleRec();
            e.ack  = 1'b1;
            e.busy = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (sel[c] && modelCount[c] != 8'hFF) begin
                    modelCount[c] = modelCount[c] - 8'(nBits[c]);
                    if (modelCount[c] == 8'h00) begin
                        e.set[c]     = 1'b1;
                        modelDone[c] = 1'b1;
                    end
                end
            end
            expQ.push_back(e);
        end else begin
            e = idleRec();
            e.ack  = 1'b1;
            e.busy = 1'b1;
            if (we && off == 2'd1) begin
                for (int c = 0; c < 4; c++) begin
                    if (sel[c]) begin
                        modelCount[c] = data[8*c +: 8];
                        modelDone[c]  = 1'b0;
                    end
                end
            end else if (!we && off == 2'd0) begin
                e.rdata = {28'h0, modelDone[3], modelDone[2], modelDone[1], modelDone[0]};
            end else if (!we && off == 2'd1) begin
                e.rdata = {modelCount[3], modelCount[2], modelCount[1], modelCount[0]};
            end
            expQ.push_back(e);
        end
    endtask

    task automatic endAccess();
        @(posedge wb_clk_i);
        #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
        applyStimulus(we, addr, data, sel);
        checkOutput(tag);
        endAccess();
    endtask

    // Linear sequence of directed steps
    initial begin
        modelReset();
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        pushIdle(1);
        checkOne("inReset");
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;

        access("rdCountReset",  1'b0, 32'h3000_0004, 32'h0, 4'hF);
        access("rdStatusReset", 1'b0, 32'h3000_0000, 32'h0, 4'hF);

        access("dataInf",       1'b1, 32'h3000_0008, 32'hA5C3_0F81, 4'hF);
        access("rdCountInf",    1'b0, 32'h3000_0004, 32'h0, 4'hF);

        access("wrCount3",      1'b1, 32'h3000_0004, 32'h0A03_0303, 4'hF);
        access("dataPartial",   1'b1, 32'h3000_0008, 32'h0000_0005, 4'hF);
        access("rdCountPart",   1'b0, 32'h3000_0004, 32'h0, 4'hF);
        access("rdStatusPart",  1'b0, 32'h3000_0000, 32'h0, 4'hF);

        access("wrCount0",      1'b1, 32'h3000_0004, 32'h0000_0000, 4'hF);
        access("dataZero",      1'b1, 32'h3000_0008, 32'hDEAD_BEEF, 4'hF);
        access("rdStatusZero",  1'b0, 32'h3000_0000, 32'h0, 4'hF);

        access("wrCount5",      1'b1, 32'h3000_0004, 32'h0505_0505, 4'hF);
        access("dataLane1",     1'b1, 32'h3000_0008, 32'h0000_FF00, 4'b0010);
        access("rdCountLane1",  1'b0, 32'h3000_0004, 32'h0, 4'hF);

        access("missWrite",     1'b1, 32'h3000_0108, 32'hFFFF_FFFF, 4'hF);
        access("rdCountMiss",   1'b0, 32'h3000_0004, 32'h0, 4'hF);
        access("rdData",        1'b0, 32'h3000_0008, 32'h0, 4'hF);
        access("rdReserved",    1'b0, 32'h3000_000C, 32'h0, 4'hF);
        access("wrReserved",    1'b1, 32'h3000_000C, 32'h1234_5678, 4'hF);
        access("rdCountResv",   1'b0, 32'h3000_0004, 32'h0, 4'hF);

        applyStimulus(1'b1, 32'h3000_0008, 32'h1234_5678, 4'hF);
        checkCycles("abortShift", 3);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i  = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge wb_clk_i);
        checkOne("abortK3");
        expQ.delete();
        modelReset();
        pushIdle(1);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOne("abortAfter");
        pushIdle(4);
        checkCycles("abortNoAck", 4);
        access("rdCountAbort",  1'b0, 32'h3000_0004, 32'h0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
